// File: rtl/traffic_ctrl_n.sv
// traffic_ctrl_n -- N-approach traffic-light controller.
//
// Serves NCH approaches in circular order. Each service is a
// GREEN -> YELLOW -> ALLRED sequence, with every interval measured in ticks
// from a prescaler. Approaches without demand are skipped. A flash-mode
// request drains any active green through yellow and then blinks all
// yellows. TEST makes every cycle a tick.
//
// Ports:
//   CK     clock, rising edge
//   CLR    synchronous reset, active-high
//   FM     flash-mode request (level, sampled on ticks)
//   TEST   tick every cycle
//   REQ    per-approach demand (level, sampled on ticks)
//   GRN    green per approach   (registered)
//   YLW    yellow per approach  (registered)
//   RED    red per approach     (registered)
//   PHASE  current / most recently served approach
module traffic_ctrl_n #(
    parameter int NCH      = 2,
    parameter int PRESC    = 4,
    parameter int GREEN_T  = 5,
    parameter int YELLOW_T = 2,
    parameter int ALLRED_T = 1,
    parameter int TW       = 8
) (
    input  logic                     CK,
    input  logic                     CLR,
    input  logic                     FM,
    input  logic                     TEST,
    input  logic [NCH-1:0]           REQ,
    output logic [NCH-1:0]           GRN,
    output logic [NCH-1:0]           YLW,
    output logic [NCH-1:0]           RED,
    output logic [$clog2(NCH)-1:0]   PHASE
);

    localparam int CW = $clog2(NCH);
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    localparam logic [TW-1:0] G_LD = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] Y_LD = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] R_LD = TW'(ALLRED_T - 1);
    localparam logic [PW-1:0] P_MAX = PW'(PRESC - 1);

    typedef enum logic [1:0] {
        S_ALLRED,
        S_GREEN,
        S_YELLOW,
        S_FLASH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            fl_q, fl_d;
    // Clear until the first service after reset; until then the search for
    // the next approach starts at channel 0 itself so ch0 is served first.
    logic            served_q, served_d;
    logic [NCH-1:0]  grn_q, grn_d;
    logic [NCH-1:0]  ylw_q, ylw_d;
    logic [NCH-1:0]  red_q, red_d;

    logic            tick;
    logic [CW-1:0]   nxt_ch;
    logic            found;
    logic [NCH-1:0]  sel;
    int              start;
    int              idx;

    assign tick = TEST | (pcnt_q == P_MAX);

    // Next approach: first one with demand scanning circularly from the slot
    // after ch; the current channel is scanned last so a lone request on it
    // re-serves it. No demand at all falls back to plain rotation.
    always_comb begin
        start  = served_q ? int'(ch_q) + 1 : 0;
        nxt_ch = CW'(start % NCH);
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (start + i) % NCH;
            if (!found && REQ[CW'(idx)]) begin
                found  = 1'b1;
                nxt_ch = CW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        tcnt_d   = tcnt_q;
        fl_d     = fl_q;
        served_d = served_q;
        pcnt_d   = (TEST || tick) ? '0 : pcnt_q + 1'b1;

        if (tick) begin
            unique case (state_q)
                S_ALLRED: begin
                    // Flash request wins over the pending green, so green is
                    // never entered while FM is high.
                    if (FM) begin
                        state_d = S_FLASH;
                        fl_d    = 1'b1;
                    end else if (tcnt_q == '0) begin
                        state_d  = S_GREEN;
                        ch_d     = nxt_ch;
                        served_d = 1'b1;
                        tcnt_d   = G_LD;
                    end else begin
                        tcnt_d = tcnt_q - 1'b1;
                    end
                end
                S_GREEN: begin
                    // Flash request cuts green short but still yields via yellow.
                    if (FM || tcnt_q == '0) begin
                        state_d = S_YELLOW;
                        tcnt_d  = Y_LD;
                    end else begin
                        tcnt_d = tcnt_q - 1'b1;
                    end
                end
                S_YELLOW: begin
                    if (tcnt_q == '0) begin
                        if (FM) begin
                            state_d = S_FLASH;
                            fl_d    = 1'b1;
                        end else begin
                            state_d = S_ALLRED;
                            tcnt_d  = R_LD;
                        end
                    end else begin
                        tcnt_d = tcnt_q - 1'b1;
                    end
                end
                S_FLASH: begin
                    if (!FM) begin
                        state_d = S_ALLRED;
                        tcnt_d  = R_LD;
                    end else begin
                        fl_d = ~fl_q;
                    end
                end
                default: begin
                    state_d = S_ALLRED;
                    tcnt_d  = R_LD;
                end
            endcase
        end

        // Lamps decoded from the next state so they change on the same edge
        // as the state register.
        sel        = '0;
        sel[ch_d]  = 1'b1;
        grn_d      = '0;
        ylw_d      = '0;
        red_d      = '1;
        unique case (state_d)
            S_GREEN: begin
                grn_d = sel;
                red_d = ~sel;
            end
            S_YELLOW: begin
                ylw_d = sel;
                red_d = ~sel;
            end
            S_FLASH: begin
                ylw_d = {NCH{fl_d}};
                red_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            state_q  <= S_ALLRED;
            ch_q     <= '0;
            tcnt_q   <= R_LD;
            pcnt_q   <= '0;
            fl_q     <= 1'b0;
            served_q <= 1'b0;
            grn_q    <= '0;
            ylw_q    <= '0;
            red_q    <= '1;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            tcnt_q   <= tcnt_d;
            pcnt_q   <= pcnt_d;
            fl_q     <= fl_d;
            served_q <= served_d;
            grn_q    <= grn_d;
            ylw_q    <= ylw_d;
            red_q    <= red_d;
        end
    end

    assign GRN   = grn_q;
    assign YLW   = ylw_q;
    assign RED   = red_q;
    assign PHASE = ch_q;

endmodule
